pmu_cfg_arb: RTL and testbench
==============================

Name: pmu_cfg_arb

Overview:
Round-robin arbiter that shares the single AD5522 configuration port of pmu_drv (write request/done, read request/done, compare result) between REQ_NUM requesters, e.g. pmu_task, a diag/warn poller and a calibration engine. It sits between those requesters and pmu_drv inside pmu_core. Each granted request is sequenced through issue, wait and response. A response timeout is enforced, and the block holds off new grants while the AD5522 reset sequence is busy.

Parameters:
REQ_NUM, 3, number of requesters (2..8)
PMU_CFG_DW, 29, AD5522 config/result word width
TMO_DW, 16, timeout counter width
ERR_CNT_DW, 8, error counter width

Ports:
clk  in  1  system clock
rstn  in  1  reset
req_valid  in  REQ_NUM  per-requester request level
req_wr  in  REQ_NUM  1=write, 0=read (readback/compare)
req_data  in  REQ_NUM*PMU_CFG_DW  packed request words; requester i occupies [i*DW +: DW]
req_gnt  out  REQ_NUM  one-hot acceptance pulse
req_done  out  REQ_NUM  one-hot completion pulse
req_err  out  1  qualifies req_done: 1 = timed out
rsp_data  out  PMU_CFG_DW  read result, valid with req_done
cfg_timeout  in  TMO_DW  wait limit in clk cycles; 0 = no timeout
drv_hold  in  1  driven from ad5522_rst_busy; blocks new grants
pmu_cfg_wr_req  out  1  write request pulse to pmu_drv
pmu_cfg_rd_req  out  1  read request pulse to pmu_drv
pmu_cfg_wr_data  out  PMU_CFG_DW  word to pmu_drv
pmu_cfg_wr_done  in  1  write completion pulse
pmu_cfg_rd_done  in  1  read completion pulse
pmu_cmp_result  in  PMU_CFG_DW  readback word
pmu_cmp_result_vld  in  1  readback valid
arb_busy  out  1  state != IDLE
err_cnt  out  ERR_CNT_DW  saturating timeout count

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state=IDLE; RR pointer=REQ_NUM-1, so requester 0 wins first. Reset mid-transaction abandons it: no done pulse, no downstream pulse.
- Handshake:
  - A requester holds req_valid, req_wr and req_data stable until req_gnt.
  - A transfer is accepted on req_valid&req_gnt. The requester drops req_valid the next cycle.
  - The requester must not re-request until its req_done.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If drv_hold=0 and |req_valid, select the first asserted requester searching from ptr+1 with wrap-around.
  - In that cycle, pulse req_gnt[idx] (registered, one cycle) and latch idx, req_wr[idx] and req_data[idx] into pmu_cfg_wr_data.
  - Go to ISSUE.
  - drv_hold=1 while IDLE: no grant.
- ISSUE:
  - One-cycle pulse: pmu_cfg_wr_req if wr, else pmu_cfg_rd_req.
  - Clear timer; clear captured result; go to WAIT.
  - Grant-to-downstream-request latency is 1 cycle.
- WAIT:
  - Timer increments each cycle.
  - Read: capture pmu_cmp_result on any pmu_cmp_result_vld, including the same cycle as rd_done; the last capture wins.
  - Write done = pmu_cfg_wr_done; read done = pmu_cfg_rd_done. The opposite-type done is ignored.
  - On done, go to RESP with err=0.
  - If cfg_timeout!=0 and timer==cfg_timeout-1 with no done, go to RESP with err=1.
  - Done and timeout in the same cycle: done wins, err=0.
- RESP:
  - One-cycle req_done[idx] with req_err and rsp_data.
  - rsp_data = captured word for reads, 0 for writes and for timeouts.
  - ptr<=idx; err_cnt+=err, saturating at all-ones.
  - Go to IDLE. The next grant occurs no earlier than the cycle after RESP.
- Stray downstream signals (done or result_vld while IDLE, ISSUE or RESP) are ignored.
- drv_hold asserted during ISSUE/WAIT/RESP does not abort the in-flight transaction.
- pmu_cfg_wr_data holds its value from grant until the next grant.

Test Plan:
- Reset/single write: rstn low then high; req_valid[0]=1, wr=1, data=29'h0ABCDEF. Required: gnt[0] pulse; wr_req 1 cycle later with wr_data=29'h0ABCDEF. Drive wr_done 5 cycles later; req_done[0] follows next cycle with err=0.
- Read: req 1, wr=0; result_vld with 29'h1234567 coincident with rd_done. Required: req_done[1] with rsp_data=29'h1234567, and no wr_req ever.
- Round-robin: all three requesting continuously (each re-requests after done). Required: grant order 0,1,2,0,1,2. After drv_hold=1 is asserted mid-WAIT, the current transaction completes and no further gnt occurs until drv_hold=0.
- Timeout: cfg_timeout=10, never return done. Required: req_done with err=1 exactly 10 cycles after ISSUE, and err_cnt=1. Timeout and done in the same cycle gives err=0 and err_cnt unchanged.
- Saturation/disable: force 300 timeouts with ERR_CNT_DW=8; required err_cnt=255. With cfg_timeout=0, WAIT holds for 10000 cycles without done.
- Async reset in WAIT: assert rstn low mid-WAIT. Required: outputs 0 immediately (before the next clk edge), no req_done afterwards, and first grant after release goes to requester 0.

Source files
------------

// File: rtl/pmu_cfg_arb.sv
// -----------------------------------------------------------------------------
// pmu_cfg_arb
//   Round-robin arbiter sharing the single AD5522 configuration port of pmu_drv
//   between REQ_NUM requesters. One request at a time moves through
//   IDLE -> ISSUE -> WAIT -> RESP. Completion is bounded by an optional
//   response timeout, and new grants are held off while drv_hold is high.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   req_valid/wr/data     per-requester request level, type (1=write), word
//   req_gnt               one-hot, one-cycle acceptance pulse
//   req_done, req_err     one-hot completion pulse; req_err=1 means timed out
//   rsp_data              read result, valid with req_done (0 for writes/timeouts)
//   cfg_timeout           WAIT limit in clk cycles, 0 disables the timeout
//   drv_hold              AD5522 reset sequence busy: no new grants
//   pmu_cfg_*             request/response port towards pmu_drv
//   arb_busy              high whenever the FSM is not IDLE
//   err_cnt               saturating count of timed-out transactions
//
// Handshake
//   A requester holds req_valid/req_wr/req_data stable until it sees req_gnt;
//   the transfer is accepted in the req_valid & req_gnt cycle, the requester
//   drops req_valid on the following cycle and must not request again before
//   its req_done pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pmu_cfg_arb #(
    parameter int REQ_NUM    = 3,
    parameter int PMU_CFG_DW = 29,
    parameter int TMO_DW     = 16,
    parameter int ERR_CNT_DW = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [REQ_NUM-1:0]            req_valid,
    input  logic [REQ_NUM-1:0]            req_wr,
    input  logic [REQ_NUM*PMU_CFG_DW-1:0] req_data,
    output logic [REQ_NUM-1:0]            req_gnt,
    output logic [REQ_NUM-1:0]            req_done,
    output logic                          req_err,
    output logic [PMU_CFG_DW-1:0]         rsp_data,
    input  logic [TMO_DW-1:0]             cfg_timeout,
    input  logic                          drv_hold,
    output logic                          pmu_cfg_wr_req,
    output logic                          pmu_cfg_rd_req,
    output logic [PMU_CFG_DW-1:0]         pmu_cfg_wr_data,
    input  logic                          pmu_cfg_wr_done,
    input  logic                          pmu_cfg_rd_done,
    input  logic [PMU_CFG_DW-1:0]         pmu_cmp_result,
    input  logic                          pmu_cmp_result_vld,
    output logic                          arb_busy,
    output logic [ERR_CNT_DW-1:0]         err_cnt
);

    localparam int IW = $clog2(REQ_NUM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic                  r_wr;
    logic [PMU_CFG_DW-1:0] r_wr_data;
    logic [TMO_DW-1:0]     r_timer;
    logic [PMU_CFG_DW-1:0] r_cap;
    logic [REQ_NUM-1:0]    r_gnt;
    logic [REQ_NUM-1:0]    r_done;
    logic                  r_err;
    logic [PMU_CFG_DW-1:0] r_rsp;
    logic                  r_wr_req;
    logic                  r_rd_req;
    logic [ERR_CNT_DW-1:0] r_err_cnt;

    logic                  w_found;
    logic [IW-1:0]         w_sel;
    logic [IW-1:0]         w_cand;
    logic [PMU_CFG_DW-1:0] w_req_word;
    logic [REQ_NUM-1:0]    w_one;
    logic                  w_done_in;
    logic [TMO_DW-1:0]     w_tmo_lim;
    logic                  w_tmo;
    logic [PMU_CFG_DW-1:0] w_rd_word;

    // Search starts one past the last served requester and wraps, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % REQ_NUM);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_req_word = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_sel == IW'(i)) begin
                w_req_word = req_data[i*PMU_CFG_DW +: PMU_CFG_DW];
            end
        end
    end

    assign w_one     = {{(REQ_NUM-1){1'b0}}, 1'b1};
    // Only the done of the in-flight transfer type counts.
    assign w_done_in = r_wr ? pmu_cfg_wr_done : pmu_cfg_rd_done;
    assign w_tmo_lim = cfg_timeout - TMO_DW'(1);
    assign w_tmo     = (cfg_timeout != '0) && (r_timer == w_tmo_lim);
    // A result arriving together with rd_done is the freshest capture.
    assign w_rd_word = pmu_cmp_result_vld ? pmu_cmp_result : r_cap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_ptr     <= IW'(REQ_NUM - 1);
            r_idx     <= '0;
            r_wr      <= 1'b0;
            r_wr_data <= '0;
            r_timer   <= '0;
            r_cap     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rsp     <= '0;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            // Pulse outputs default low; each state raises what it owns.
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rsp    <= '0;
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!drv_hold && w_found) begin
                        r_gnt     <= w_one << w_sel;
                        r_idx     <= w_sel;
                        r_wr      <= req_wr[w_sel];
                        r_wr_data <= w_req_word;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wr_req <= r_wr;
                    r_rd_req <= !r_wr;
                    r_timer  <= '0;
                    r_cap    <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TMO_DW'(1);
                    if (!r_wr && pmu_cmp_result_vld) begin
                        r_cap <= pmu_cmp_result;
                    end
                    if (w_done_in) begin
                        r_done  <= w_one << r_idx;
                        r_err   <= 1'b0;
                        r_rsp   <= r_wr ? '0 : w_rd_word;
                        r_state <= S_RESP;
                    end else if (w_tmo) begin
                        r_done  <= w_one << r_idx;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ptr <= r_idx;
                    if (r_err && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + ERR_CNT_DW'(1);
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_gnt         = r_gnt;
    assign req_done        = r_done;
    assign req_err         = r_err;
    assign rsp_data        = r_rsp;
    assign pmu_cfg_wr_req  = r_wr_req;
    assign pmu_cfg_rd_req  = r_rd_req;
    assign pmu_cfg_wr_data = r_wr_data;
    assign arb_busy        = (r_state != S_IDLE);
    assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_pmu_cfg_arb.sv
`timescale 1ns/1ps
module tb_pmu_cfg_arb;

  localparam int REQ_NUM = 3;
  localparam int DW      = 29;
  localparam int TMO_DW  = 16;
  localparam int ECW     = 8;
  localparam int W_D     = REQ_NUM + 1 + DW;

  logic                  clk;
  logic                  rstn;
  logic [REQ_NUM-1:0]    req_valid;
  logic [REQ_NUM-1:0]    req_wr;
  logic [REQ_NUM*DW-1:0] req_data;
  logic [REQ_NUM-1:0]    req_gnt;
  logic [REQ_NUM-1:0]    req_done;
  logic                  req_err;
  logic [DW-1:0]         rsp_data;
  logic [TMO_DW-1:0]     cfg_timeout;
  logic                  drv_hold;
  logic                  pmu_cfg_wr_req;
  logic                  pmu_cfg_rd_req;
  logic [DW-1:0]         pmu_cfg_wr_data;
  logic                  pmu_cfg_wr_done;
  logic                  pmu_cfg_rd_done;
  logic [DW-1:0]         pmu_cmp_result;
  logic                  pmu_cmp_result_vld;
  logic                  arb_busy;
  logic [ECW-1:0]        err_cnt;

  int total = 0;
  int bad = 0;
  int n_wr_req = 0;
  int n_done = 0;

  logic [REQ_NUM-1:0] gnt_q[$];
  logic [W_D-1:0]     exp_q[$];
  logic [DW-1:0]      d [3];
  logic [REQ_NUM-1:0] m_ge;
  logic [W_D-1:0]     m_de;

  pmu_cfg_arb #(.REQ_NUM(REQ_NUM), .PMU_CFG_DW(DW), .TMO_DW(TMO_DW), .ERR_CNT_DW(ECW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_wr(req_wr), .req_data(req_data),
    .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err), .rsp_data(rsp_data),
    .cfg_timeout(cfg_timeout), .drv_hold(drv_hold),
    .pmu_cfg_wr_req(pmu_cfg_wr_req), .pmu_cfg_rd_req(pmu_cfg_rd_req),
    .pmu_cfg_wr_data(pmu_cfg_wr_data), .pmu_cfg_wr_done(pmu_cfg_wr_done),
    .pmu_cfg_rd_done(pmu_cfg_rd_done), .pmu_cmp_result(pmu_cmp_result),
    .pmu_cmp_result_vld(pmu_cmp_result_vld),
    .arb_busy(arb_busy), .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W_D-1:0] dexp(input int idx, input logic err, input logic [DW-1:0] data);
    logic [REQ_NUM-1:0] oh;
    oh = REQ_NUM'(1) << idx;
    return {oh, err, data};
  endfunction

  // scoreboard: grants and completions are popped as the DUT produces them
  always @(negedge clk) begin
    if (rstn) begin
      if (pmu_cfg_wr_req) n_wr_req++;
      if (req_gnt != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", {61'd0, req_gnt}, 64'd0);
        else begin
          m_ge = gnt_q.pop_front();
          chk("gnt_order", {61'd0, req_gnt}, {61'd0, m_ge});
        end
      end
      if (req_done != '0) begin
        n_done++;
        if (exp_q.size() == 0) chk("done_unexpected", {61'd0, req_done}, 64'd0);
        else begin
          m_de = exp_q.pop_front();
          chk("done_word", {31'd0, req_done, req_err, rsp_data}, {31'd0, m_de});
        end
      end
    end
  end

  // driver tasks
  task automatic wait_gnt(input string tag, output int idx);
    int n;
    n = 0;
    while (req_gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_gnt_seen"}, {63'd0, req_gnt != '0}, 64'd1);
    case (req_gnt)
      3'b010:  idx = 1;
      3'b100:  idx = 2;
      default: idx = 0;
    endcase
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (req_done == '0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, {63'd0, req_done != '0}, 64'd1);
  endtask

  // Called in the grant cycle; returns in the req_done cycle.
  task automatic serve(input string tag, input int idx, input logic iswr,
                       input logic [DW-1:0] res, input logic hold);
    tick();
    req_valid = req_valid & ~(REQ_NUM'(1) << idx);
    chk({tag, "_type"}, {62'd0, pmu_cfg_wr_req, pmu_cfg_rd_req}, iswr ? 64'd2 : 64'd1);
    chk({tag, "_wdata"}, {35'd0, pmu_cfg_wr_data}, {35'd0, d[idx[1:0]]});
    tick();
    if (hold) drv_hold = 1'b1;
    tick();
    if (iswr) pmu_cfg_wr_done = 1'b1;
    else begin
      pmu_cfg_rd_done = 1'b1;
      pmu_cmp_result_vld = 1'b1;
      pmu_cmp_result = res;
    end
    exp_q.push_back(dexp(idx, 1'b0, iswr ? {DW{1'b0}} : res));
    tick();
    pmu_cfg_wr_done = 1'b0;
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result_vld = 1'b0;
    chk({tag, "_done"}, {61'd0, req_done}, {61'd0, REQ_NUM'(1) << idx});
  endtask

  initial begin
    int idx;
    int n;
    int snap;
    rstn = 1'b0;
    req_valid = '0;
    req_wr = '0;
    cfg_timeout = '0;
    drv_hold = 1'b0;
    pmu_cfg_wr_done = 1'b0;
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result = '0;
    pmu_cmp_result_vld = 1'b0;
    d[0] = 29'h0ABCDEF;
    d[1] = 29'h0111111;
    d[2] = 29'h0222222;
    req_data = {d[2], d[1], d[0]};
    repeat (3) tick();

    // reset state
    chk("rst_gnt", {61'd0, req_gnt}, 64'd0);
    chk("rst_done", {61'd0, req_done}, 64'd0);
    chk("rst_busy", {63'd0, arb_busy}, 64'd0);
    chk("rst_wdata", {35'd0, pmu_cfg_wr_data}, 64'd0);
    chk("rst_errcnt", {56'd0, err_cnt}, 64'd0);
    chk("rst_req", {62'd0, pmu_cfg_wr_req, pmu_cfg_rd_req}, 64'd0);
    rstn = 1'b1;
    tick();

    // single write on requester 0
    req_wr = 3'b001;
    gnt_q.push_back(3'b001);
    req_valid = 3'b001;
    wait_gnt("wr", idx);
    tick();
    req_valid = '0;
    chk("wr_req", {63'd0, pmu_cfg_wr_req}, 64'd1);
    chk("wr_no_rdreq", {63'd0, pmu_cfg_rd_req}, 64'd0);
    chk("wr_data", {35'd0, pmu_cfg_wr_data}, 64'h0ABCDEF);
    repeat (4) tick();
    chk("wr_busy", {63'd0, arb_busy}, 64'd1);
    pmu_cfg_wr_done = 1'b1;
    exp_q.push_back(dexp(0, 1'b0, '0));
    tick();
    pmu_cfg_wr_done = 1'b0;
    chk("wr_done_lat", {61'd0, req_done}, 64'd1);
    chk("wr_err", {63'd0, req_err}, 64'd0);
    tick();
    chk("wr_idle", {63'd0, arb_busy}, 64'd0);
    chk("wr_data_hold", {35'd0, pmu_cfg_wr_data}, 64'h0ABCDEF);

    // stray downstream signals while idle
    pmu_cfg_wr_done = 1'b1;
    pmu_cfg_rd_done = 1'b1;
    pmu_cmp_result_vld = 1'b1;
    pmu_cmp_result = 29'h1FFFFFF;
    tick();
    pmu_cfg_wr_done = 1'b0;
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result_vld = 1'b0;
    tick();
    chk("stray_idle", {63'd0, arb_busy}, 64'd0);

    // read on requester 1, earlier capture overwritten, wr_done ignored
    snap = n_wr_req;
    req_wr = 3'b000;
    gnt_q.push_back(3'b010);
    req_valid = 3'b010;
    wait_gnt("rd", idx);
    tick();
    req_valid = '0;
    chk("rd_req", {62'd0, pmu_cfg_wr_req, pmu_cfg_rd_req}, 64'd1);
    chk("rd_wdata", {35'd0, pmu_cfg_wr_data}, 64'h0111111);
    tick();
    pmu_cmp_result_vld = 1'b1;
    pmu_cmp_result = 29'h0FFFFFF;
    tick();
    pmu_cmp_result_vld = 1'b0;
    pmu_cfg_wr_done = 1'b1;
    tick();
    pmu_cfg_wr_done = 1'b0;
    chk("rd_ign_wrdone", {63'd0, arb_busy}, 64'd1);
    pmu_cfg_rd_done = 1'b1;
    pmu_cmp_result_vld = 1'b1;
    pmu_cmp_result = 29'h1234567;
    exp_q.push_back(dexp(1, 1'b0, 29'h1234567));
    tick();
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result_vld = 1'b0;
    chk("rd_rsp", {35'd0, rsp_data}, 64'h1234567);
    tick();
    chk("rd_no_wrreq", n_wr_req, snap);

    // asynchronous reset in WAIT
    gnt_q.push_back(3'b100);
    req_valid = 3'b100;
    wait_gnt("arst", idx);
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, arb_busy}, 64'd0);
    chk("arst_wdata", {35'd0, pmu_cfg_wr_data}, 64'd0);
    chk("arst_pulses", {58'd0, req_gnt, req_done}, 64'd0);
    pmu_cfg_rd_done = 1'b1;
    pmu_cmp_result_vld = 1'b1;
    @(posedge clk);
    #1;
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result_vld = 1'b0;
    tick();
    snap = n_done;
    rstn = 1'b1;
    repeat (3) tick();
    chk("arst_no_done", n_done, snap);

    // round robin, all three requesting continuously
    req_wr = 3'b101;
    gnt_q.push_back(3'b001); gnt_q.push_back(3'b010); gnt_q.push_back(3'b100);
    gnt_q.push_back(3'b001); gnt_q.push_back(3'b010); gnt_q.push_back(3'b100);
    gnt_q.push_back(3'b001);
    req_valid = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_gnt("rr", idx);
      chk("rr_idx", idx, g % 3);
      serve("rr", idx, idx != 1, 29'h1555000 + DW'(g), 1'b0);
      tick();
      req_valid = req_valid | (REQ_NUM'(1) << idx);
    end
    // drv_hold raised mid-WAIT: transfer completes, no new grant
    wait_gnt("hold", idx);
    serve("hold", idx, 1'b1, '0, 1'b1);
    tick();
    req_valid = req_valid | 3'b001;
    for (int k = 0; k < 8; k++) begin
      chk("hold_no_gnt", {61'd0, req_gnt}, 64'd0);
      tick();
    end
    chk("hold_idle", {63'd0, arb_busy}, 64'd0);
    gnt_q.push_back(3'b010);
    drv_hold = 1'b0;
    wait_gnt("unhold", idx);
    chk("unhold_idx", idx, 1);
    serve("unhold", idx, 1'b0, 29'h0C0FFEE, 1'b0);
    req_valid = '0;
    tick();

    // timeout after 10 cycles, late result ignored
    cfg_timeout = 16'd10;
    req_wr = 3'b000;
    gnt_q.push_back(3'b100);
    exp_q.push_back(dexp(2, 1'b1, '0));
    req_valid = 3'b100;
    wait_gnt("tmo", idx);
    tick();
    req_valid = '0;
    chk("tmo_rdreq", {63'd0, pmu_cfg_rd_req}, 64'd1);
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      pmu_cmp_result_vld = (n == 3);
      pmu_cmp_result = 29'h0DEAD00;
      if (req_done != '0) break;
    end
    pmu_cmp_result_vld = 1'b0;
    chk("tmo_latency", n, 10);
    chk("tmo_err", {63'd0, req_err}, 64'd1);
    tick();
    chk("tmo_errcnt", {56'd0, err_cnt}, 64'd1);

    // done and timeout in the same cycle: done wins
    gnt_q.push_back(3'b001);
    req_valid = 3'b001;
    wait_gnt("tie", idx);
    tick();
    req_valid = '0;
    repeat (9) tick();
    pmu_cfg_rd_done = 1'b1;
    pmu_cmp_result_vld = 1'b1;
    pmu_cmp_result = 29'h0000ABC;
    exp_q.push_back(dexp(0, 1'b0, 29'h0000ABC));
    tick();
    pmu_cfg_rd_done = 1'b0;
    pmu_cmp_result_vld = 1'b0;
    chk("tie_done", {61'd0, req_done}, 64'd1);
    chk("tie_err", {63'd0, req_err}, 64'd0);
    tick();
    chk("tie_errcnt", {56'd0, err_cnt}, 64'd1);

    // saturation of err_cnt
    cfg_timeout = 16'd1;
    req_wr = 3'b001;
    for (int k = 0; k < 300; k++) begin
      gnt_q.push_back(3'b001);
      exp_q.push_back(dexp(0, 1'b1, '0));
      req_valid = 3'b001;
      wait_gnt("sat", idx);
      tick();
      req_valid = '0;
      wait_done("sat", n);
      tick();
      if (k == 252) chk("sat_mid", {56'd0, err_cnt}, 64'd254);
    end
    chk("sat_errcnt", {56'd0, err_cnt}, 64'd255);

    // timeout disabled: WAIT holds indefinitely
    cfg_timeout = '0;
    req_wr = 3'b010;
    gnt_q.push_back(3'b010);
    req_valid = 3'b010;
    wait_gnt("dis", idx);
    tick();
    req_valid = '0;
    snap = n_done;
    repeat (10000) tick();
    chk("dis_busy", {63'd0, arb_busy}, 64'd1);
    chk("dis_no_done", n_done, snap);
    pmu_cfg_wr_done = 1'b1;
    exp_q.push_back(dexp(1, 1'b0, '0));
    tick();
    pmu_cfg_wr_done = 1'b0;
    chk("dis_done", {61'd0, req_done}, 64'd2);
    repeat (3) tick();

    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
